exec_ctrl: RTL and testbench

Multi-cycle execute/write-back sequencer of the cube 8-bit datapath. Accepts 16-bit instruction words over a valid/ready handshake and drives the register file's read addresses. It captures the two combinational read operands, computes an ALU result with zero/carry flags, and issues a single-cycle write-back (dst/we/data) into the register file. It sits directly upstream of the register file's write port and downstream of its read port.

---
 rtl/cube_pkg.sv | 54 +++++
 rtl/cube_alu.sv | 46 ++++
 rtl/exec_ctrl.sv | 104 ++++++++++
 tb/tb_exec_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the cube execute/write-back sequencer.
// Opcode A (MUL) is legal only when CUBE_MUL_EN is defined.
package cube_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h7;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h8;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h9;
  localparam logic [OP_W-1:0] OP_MUL  = 4'hA;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {IDLE, RD, EX, WB, HALTED} state_t;

  // Instruction field LSBs: {op, dst, src0, src1}, each field ADDR_W wide except op
  function automatic int op_lsb(input int aw);
    return 3 * aw;
  endfunction
  function automatic int dst_lsb(input int aw);
    return 2 * aw;
  endfunction
  function automatic int src0_lsb(input int aw);
    return aw;
  endfunction
  function automatic int src1_lsb(input int aw);
    return 0;
  endfunction

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    logic legal;
    legal = (op <= OP_MOV) || (op == OP_HALT);
`ifdef CUBE_MUL_EN
    legal = legal || (op == OP_MUL);
`endif
    return legal;
  endfunction

  function automatic logic op_writes(input logic [OP_W-1:0] op);
    logic wr;
    wr = (op >= OP_LDI) && (op <= OP_MOV);
`ifdef CUBE_MUL_EN
    wr = wr || (op == OP_MUL);
`endif
    return wr;
  endfunction

endpackage

// File: rtl/cube_alu.sv
// Combinational ALU for the cube datapath: result, carry and flag-update qualifier.
// The multiplier exists only when CUBE_MUL_EN is defined.
module cube_alu import cube_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              cf,
  output logic              writes_flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef CUBE_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  always_comb begin
    result       = '0;
    cf           = 1'b0;
    writes_flags = 1'b0;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0];  cf = sum[DATA_W];  writes_flags = 1'b1; end
      // Borrow out of the extended subtraction is exactly a < b
      OP_SUB: begin result = diff[DATA_W-1:0]; cf = diff[DATA_W]; writes_flags = 1'b1; end
      OP_AND: begin result = a & b; writes_flags = 1'b1; end
      OP_OR:  begin result = a | b; writes_flags = 1'b1; end
      OP_XOR: begin result = a ^ b; writes_flags = 1'b1; end
      OP_SHL: begin result = {a[DATA_W-2:0], 1'b0}; cf = a[DATA_W-1]; writes_flags = 1'b1; end
      OP_SHR: begin result = {1'b0, a[DATA_W-1:1]}; cf = a[0];        writes_flags = 1'b1; end
      OP_MOV: result = a;
`ifdef CUBE_MUL_EN
      OP_MUL: begin result = prod[DATA_W-1:0]; cf = |prod[2*DATA_W-1:DATA_W]; writes_flags = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Four-cycle execute/write-back sequencer (IDLE->RD->EX->WB) feeding the register file.
// Define CUBE_MUL_EN to make opcode A an 8x8 multiply; otherwise it is illegal.
module exec_ctrl import cube_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OP_W+3*ADDR_W-1:0] instr,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  output logic [ADDR_W-1:0]       src0,
  output logic [ADDR_W-1:0]       src1,
  input  logic [DATA_W-1:0]       data0,
  input  logic [DATA_W-1:0]       data1,
  output logic [ADDR_W-1:0]       dst,
  output logic                    we,
  output logic [DATA_W-1:0]       data,
  output logic                    zf,
  output logic                    cf,
  output logic                    illegal,
  output logic                    halted
);

  localparam int IW = OP_W + 3 * ADDR_W;

  state_t              state, state_nx;
  logic [IW-1:0]       ir;
  logic [OP_W-1:0]     ir_op;
  logic [DATA_W-1:0]   ir_imm;
  logic [DATA_W-1:0]   opa_p1, opb_p1;
  logic [DATA_W-1:0]   res_p2;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_cf, alu_wf;

  assign ir_op  = ir[op_lsb(ADDR_W) +: OP_W];
  // LDI immediate overlays both source fields (DATA_W == 2*ADDR_W)
  assign ir_imm = ir[src1_lsb(ADDR_W) +: DATA_W];
  assign src0   = ir[src0_lsb(ADDR_W) +: ADDR_W];
  assign src1   = ir[src1_lsb(ADDR_W) +: ADDR_W];
  assign dst    = ir[dst_lsb(ADDR_W) +: ADDR_W];
  assign data   = res_p2;

  cube_alu #(.DATA_W(DATA_W)) u_alu (
    .op           (ir_op),
    .a            (opa_p1),
    .b            (opb_p1),
    .result       (alu_res),
    .cf           (alu_cf),
    .writes_flags (alu_wf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (instr_valid) state_nx = RD;
      RD:      state_nx = EX;
      EX:      state_nx = (ir_op == OP_HALT) ? HALTED : WB;
      WB:      state_nx = IDLE;
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    we          = (state == WB) && op_writes(ir_op);
    illegal     = (state == WB) && !op_is_legal(ir_op);
    halted      = (state == HALTED);
  end

  // Stage p0: instruction register; p2: result and flags at the EX->WB edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      res_p2 <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == EX) begin
        if (op_writes(ir_op)) res_p2 <= (ir_op == OP_LDI) ? ir_imm : alu_res;
        if (alu_wf) begin
          zf <= (alu_res == '0);
          cf <= alu_cf;
        end
      end
    end
  end

  // Stage p1: operand capture from the register file read port
  always_ff @(posedge clk) begin
    if (state == RD) begin
      opa_p1 <= data0;
      opb_p1 <= data1;
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed vector table, reset/halt sequences,
// and random instructions checked against an arithmetic reference model.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  src0, src1, dst;
  logic [7:0]  data0, data1, data;
  logic        we, zf, cf, illegal, halted;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CUBE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  exec_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .src0        (src0),
    .src1        (src1),
    .data0       (data0),
    .data1       (data1),
    .dst         (dst),
    .we          (we),
    .data        (data),
    .zf          (zf),
    .cf          (cf),
    .illegal     (illegal),
    .halted      (halted)
  );

  // Register file environment: combinational read, write on we
  logic [7:0] rf [16];
  assign data0 = rf[src0];
  assign data1 = rf[src1];
  always @(posedge clk) if (we) rf[dst] <= data;

  // Reference model state
  logic [7:0] mrf [16];
  bit         mzf = 1'b0;
  bit         mcf = 1'b0;

  typedef struct {
    logic [15:0] ins;
    bit          we;
    logic [7:0]  d;
    bit          zf;
    bit          cf;
    bit          ill;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [15:0] ins, input bit w, input logic [7:0] d,
                             input bit z, input bit c, input bit il, input string nm);
    vec_t r;
    r.ins = ins; r.we = w; r.d = d; r.zf = z; r.cf = c; r.ill = il; r.name = nm;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the architectural rules
  task automatic model_step(input logic [15:0] ins, output bit ewe, output logic [7:0] ed,
                            output bit ezf, output bit ecf, output bit eill);
    int op, a, b, r;
    bit fl, c;
    op = int'(ins[15:12]);
    a  = int'(mrf[ins[7:4]]);
    b  = int'(mrf[ins[3:0]]);
    r = 0; fl = 0; c = 0; ewe = 0; eill = 0;
    case (op)
      0:  ;
      1:  begin r = int'(ins[7:0]); ewe = 1; end
      2:  begin r = a + b; c = (r > 255); fl = 1; ewe = 1; end
      3:  begin r = a - b + 256; c = (a < b); fl = 1; ewe = 1; end
      4:  begin r = a & b; fl = 1; ewe = 1; end
      5:  begin r = a | b; fl = 1; ewe = 1; end
      6:  begin r = a ^ b; fl = 1; ewe = 1; end
      7:  begin r = a * 2; c = (a >= 128); fl = 1; ewe = 1; end
      8:  begin r = a / 2; c = (a % 2 == 1); fl = 1; ewe = 1; end
      9:  begin r = a; ewe = 1; end
      10: if (MUL_EN) begin r = a * b; c = (r > 255); fl = 1; ewe = 1; end
          else eill = 1;
      default: eill = 1;
    endcase
    r = r % 256;
    if (ewe) mrf[ins[11:8]] = 8'(r);
    if (fl) begin mzf = (r == 0); mcf = c; end
    ed = 8'(r); ezf = mzf; ecf = mcf;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (instr_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (instr_ready !== 1'b1) chk1({name, "_ready_timeout"}, instr_ready, 1'b1);
  endtask

  // Issue one instruction from a negedge and check every phase up to the next IDLE
  task automatic run_instr(input logic [15:0] ins, input bit ewe, input logic [7:0] ed,
                           input bit ezf, input bit ecf, input bit eill, input string name);
    wait_ready(name);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    @(negedge clk);
    chk1({name, "_rd_we"}, we, 1'b0);
    chk1({name, "_rd_ready"}, instr_ready, 1'b0);
    chk8({name, "_src0"}, {4'b0, src0}, {4'b0, ins[7:4]});
    chk8({name, "_src1"}, {4'b0, src1}, {4'b0, ins[3:0]});
    @(negedge clk);
    chk1({name, "_ex_we"}, we, 1'b0);
    @(negedge clk);
    chk1({name, "_wb_we"}, we, ewe);
    chk1({name, "_wb_illegal"}, illegal, eill);
    chk1({name, "_wb_zf"}, zf, ezf);
    chk1({name, "_wb_cf"}, cf, ecf);
    if (ewe) begin
      chk8({name, "_wb_dst"}, {4'b0, dst}, {4'b0, ins[11:8]});
      chk8({name, "_wb_data"}, data, ed);
    end
    @(negedge clk);
    chk1({name, "_post_ready"}, instr_ready, 1'b1);
    chk1({name, "_post_illegal"}, illegal, 1'b0);
    chk1({name, "_post_we"}, we, 1'b0);
  endtask

  task automatic run_model(input logic [15:0] ins, input string name);
    bit w, z, c, il;
    logic [7:0] d;
    model_step(ins, w, d, z, c, il);
    run_instr(ins, w, d, z, c, il, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bit w, z, c, il;
    logic [7:0] d;

    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk1("rst_ready", instr_ready, 1'b1);
    chk1("rst_we", we, 1'b0);
    chk8("rst_data", data, 8'h00);
    chk8("rst_dst", {4'b0, dst}, 8'h00);
    chk8("rst_src0", {4'b0, src0}, 8'h00);
    chk1("rst_zf", zf, 1'b0);
    chk1("rst_cf", cf, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    tbl.push_back(v(16'h132A, 1, 8'h2A, 0, 0, 0, "ldi_r3"));
    tbl.push_back(v(16'h11F0, 1, 8'hF0, 0, 0, 0, "ldi_r1"));
    tbl.push_back(v(16'h1220, 1, 8'h20, 0, 0, 0, "ldi_r2"));
    tbl.push_back(v(16'h2412, 1, 8'h10, 0, 1, 0, "add_carry"));
    tbl.push_back(v(16'h3522, 1, 8'h00, 1, 0, 0, "sub_zero"));
    tbl.push_back(v(16'h1181, 1, 8'h81, 1, 0, 0, "ldi_r1_81"));
    tbl.push_back(v(16'h7610, 1, 8'h02, 0, 1, 0, "shl"));
    tbl.push_back(v(16'h1701, 1, 8'h01, 0, 1, 0, "ldi_r7"));
    tbl.push_back(v(16'h8870, 1, 8'h00, 1, 1, 0, "shr"));
    tbl.push_back(v(16'hB000, 0, 8'h00, 1, 1, 1, "op_b"));
    tbl.push_back(v(16'h1110, 1, 8'h10, 1, 1, 0, "ldi_r1_10"));
    tbl.push_back(v(16'h1211, 1, 8'h11, 1, 1, 0, "ldi_r2_11"));
`ifdef CUBE_MUL_EN
    tbl.push_back(v(16'hA312, 1, 8'h10, 0, 1, 0, "mul"));
    tbl.push_back(v(16'h9940, 1, 8'h10, 0, 1, 0, "mov"));
`else
    tbl.push_back(v(16'hA312, 0, 8'h00, 1, 1, 1, "op_a_illegal"));
    tbl.push_back(v(16'h9940, 1, 8'h10, 1, 1, 0, "mov"));
`endif
    tbl.push_back(v(16'h4A12, 1, 8'h10, 0, 0, 0, "and"));
    tbl.push_back(v(16'h5B12, 1, 8'h11, 0, 0, 0, "or"));
    tbl.push_back(v(16'h6C12, 1, 8'h01, 0, 0, 0, "xor"));
    tbl.push_back(v(16'h6D11, 1, 8'h00, 1, 0, 0, "xor_self"));
    tbl.push_back(v(16'h0000, 0, 8'h00, 1, 0, 0, "nop"));
    tbl.push_back(v(16'h3E12, 1, 8'hFF, 0, 1, 0, "sub_borrow"));

    foreach (tbl[i]) begin
      model_step(tbl[i].ins, w, d, z, c, il);
      run_instr(tbl[i].ins, tbl[i].we, tbl[i].d, tbl[i].zf, tbl[i].cf, tbl[i].ill, tbl[i].name);
    end

    // Reset during EX of an ADD: no write, immediate return to reset values
    wait_ready("rst_ex");
    instr = 16'h2E12; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk1("rst_ex_we", we, 1'b0);
    chk1("rst_ex_ready", instr_ready, 1'b1);
    chk8("rst_ex_dst", {4'b0, dst}, 8'h00);
    chk8("rst_ex_src0", {4'b0, src0}, 8'h00);
    chk8("rst_ex_src1", {4'b0, src1}, 8'h00);
    chk8("rst_ex_data", data, 8'h00);
    chk1("rst_ex_zf", zf, 1'b0);
    chk1("rst_ex_cf", cf, 1'b0);
    chk1("rst_ex_illegal", illegal, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mzf = 1'b0; mcf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("rst_ex_after_we", we, 1'b0);
      chk1("rst_ex_after_ready", instr_ready, 1'b1);
    end

    // Define every register before random traffic reads it
    for (int r = 0; r < 16; r++) run_model({4'h1, 4'(r), 8'($urandom)}, "init_ldi");

    for (int n = 0; n < 120; n++)
      run_model({4'($urandom_range(0, 14)), 12'($urandom)}, "rand");

    // HALT with instr_valid held high
    wait_ready("halt");
    instr = 16'hF000; instr_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("halt_rd_ready", instr_ready, 1'b0);
    chk1("halt_rd_halted", halted, 1'b0);
    @(negedge clk);
    chk1("halt_ex_halted", halted, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk1("halted_flag", halted, 1'b1);
      chk1("halted_ready", instr_ready, 1'b0);
      chk1("halted_we", we, 1'b0);
    end
    #1 rst = 1'b1;
    #1;
    chk1("halt_rst_halted", halted, 1'b0);
    chk1("halt_rst_ready", instr_ready, 1'b1);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mzf = 1'b0; mcf = 1'b0;
    @(negedge clk);
    run_model(16'h1155, "post_halt_ldi");
    run_model(16'h2211, "post_halt_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
